// File: rtl/trng_pkg.sv
// Shared constants and the von Neumann pair-state type for the TRNG collector.
package trng_pkg;

    localparam int SAMPLE_DIV_DEF = 16;
    localparam int RCT_LIMIT_DEF  = 32;
    localparam int BYTE_W         = 8;

    typedef enum logic {
        VN_FIRST  = 1'b0,
        VN_SECOND = 1'b1
    } vn_state_e;

endpackage

// File: rtl/trng_vn_extractor.sv
// Von Neumann debiaser: consumes sample pairs, emits b0 for 10/01 pairs, nothing for 00/11.
module trng_vn_extractor
    import trng_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic i_enable,
    input  logic i_strobe,
    input  logic i_sbit,
    output logic o_bit_valid,
    output logic o_bit_out
);

    vn_state_e r_state;
    logic      r_b0;

    // Dropping enable discards a half-collected pair so pairing restarts cleanly.
    always_ff @(posedge clk) begin
        if (!rst_n || !i_enable) begin
            r_state     <= VN_FIRST;
            r_b0        <= 1'b0;
            o_bit_valid <= 1'b0;
            o_bit_out   <= 1'b0;
        end else begin
            o_bit_valid <= 1'b0;
            if (i_strobe) begin
                case (r_state)
                    VN_FIRST: begin
                        r_b0    <= i_sbit;
                        r_state <= VN_SECOND;
                    end
                    VN_SECOND: begin
                        r_state <= VN_FIRST;
                        if (r_b0 != i_sbit) begin
                            o_bit_valid <= 1'b1;
                            o_bit_out   <= r_b0;
                        end
                    end
                    default: r_state <= VN_FIRST;
                endcase
            end
        end
    end

endmodule

// File: rtl/trng_collector.sv
// TRNG raw-bit collector: sync, sample, debias, pack to bytes, valid/ready out, RCT health test.
// Define TRNG_RAW_BYPASS_EN to add raw_mode, which packs every sample without debiasing.
module trng_collector
    import trng_pkg::*;
#(
    parameter int SAMPLE_DIV = SAMPLE_DIV_DEF,
    parameter int RCT_LIMIT  = RCT_LIMIT_DEF,
    parameter int CNT_W      = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              raw_bit,
`ifdef TRNG_RAW_BYPASS_EN
    input  logic              raw_mode,
`endif
    output logic [BYTE_W-1:0] data_out,
    output logic              data_valid,
    input  logic              data_ready,
    output logic              overflow,
    output logic              health_fail
);

    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(SAMPLE_DIV - 1);
    localparam logic [CNT_W-1:0] RCT_MAX  = CNT_W'(RCT_LIMIT);

    logic              r_sync1, r_sync2;
    logic [CNT_W-1:0]  r_div, r_run;
    logic              r_prev;
    logic [BYTE_W-1:0] r_shift, r_data;
    logic [2:0]        r_bitcnt;
    logic              r_valid, r_ovf, r_hfail;

    logic              w_strobe, w_vn_valid, w_vn_bit, w_bit_valid, w_bit;
    logic              w_complete, w_xfer, w_load;
    logic [CNT_W-1:0]  w_run_next;
    logic [BYTE_W-1:0] w_next_byte;

    assign w_strobe = enable && (r_div == DIV_LAST);

    trng_vn_extractor u_vn (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_enable    (enable),
        .i_strobe    (w_strobe),
        .i_sbit      (r_sync2),
        .o_bit_valid (w_vn_valid),
        .o_bit_out   (w_vn_bit)
    );

`ifdef TRNG_RAW_BYPASS_EN
    assign w_bit_valid = raw_mode ? w_strobe : w_vn_valid;
    assign w_bit       = raw_mode ? r_sync2  : w_vn_bit;
`else
    assign w_bit_valid = w_vn_valid;
    assign w_bit       = w_vn_bit;
`endif

    // Run count starts at 0 after reset, so the first sample always lands on a run of 1.
    assign w_run_next  = (r_sync2 == r_prev) ? ((r_run == RCT_MAX) ? r_run : r_run + CNT_W'(1))
                                              : CNT_W'(1);
    assign w_next_byte = {r_shift[BYTE_W-2:0], w_bit};
    assign w_complete  = enable && w_bit_valid && (r_bitcnt == 3'd7) && !r_hfail;
    assign w_xfer      = r_valid && data_ready;
    assign w_load      = w_complete && (!r_valid || w_xfer);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_div    <= '0;
            r_run    <= '0;
            r_prev   <= 1'b0;
            r_shift  <= '0;
            r_bitcnt <= '0;
            r_data   <= '0;
            r_valid  <= 1'b0;
            r_ovf    <= 1'b0;
            r_hfail  <= 1'b0;
        end else begin
            r_sync1 <= raw_bit;
            r_sync2 <= r_sync1;

            if (!enable || w_strobe) r_div <= '0;
            else                     r_div <= r_div + CNT_W'(1);

            if (w_strobe) begin
                r_prev <= r_sync2;
                r_run  <= w_run_next;
                if (w_run_next == RCT_MAX) r_hfail <= 1'b1;
            end

            if (!enable) begin
                r_shift  <= '0;
                r_bitcnt <= '0;
            end else if (w_bit_valid) begin
                r_shift  <= w_next_byte;
                r_bitcnt <= r_bitcnt + 3'd1;
            end

            // A held byte is never overwritten; a completion that cannot load is an overflow.
            if (w_load) begin
                r_data  <= w_next_byte;
                r_valid <= 1'b1;
            end else if (w_complete) begin
                r_ovf   <= 1'b1;
            end else if (w_xfer) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign data_out    = r_data;
    assign data_valid  = r_valid;
    assign overflow    = r_ovf;
    assign health_fail = r_hfail;

endmodule

// File: tb/tb_trng_collector.sv
// Directed self-checking bench for trng_collector (default parameters, default build).
module tb_trng_collector;

    localparam int SDIV = 16;

    logic       clk = 1'b0;
    logic       rst_n, enable, raw_bit, data_ready;
    logic [7:0] data_out;
    logic       data_valid, overflow, health_fail;

    int         tests = 0;
    int         fails = 0;
    int         vld_cycles = 0;
    logic [7:0] got[$];

    always #5 clk = ~clk;

    trng_collector dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .raw_bit     (raw_bit),
`ifdef TRNG_RAW_BYPASS_EN
        .raw_mode    (1'b0),
`endif
        .data_out    (data_out),
        .data_valid  (data_valid),
        .data_ready  (data_ready),
        .overflow    (overflow),
        .health_fail (health_fail)
    );

    // Record every accepted byte and every cycle with data_valid high.
    always @(negedge clk) begin
        if (rst_n) begin
            if (data_valid) vld_cycles = vld_cycles + 1;
            if (data_valid && data_ready) got.push_back(data_out);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests = tests + 1;
        assert (obs === exp) else begin
            fails = fails + 1;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] first_byte();
        return (got.size() > 0) ? {24'h0, got[0]} : 32'hFFFF_FFFF;
    endfunction

    task automatic do_reset();
        rst_n   = 1'b0;
        enable  = 1'b0;
        raw_bit = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        got.delete();
        vld_cycles = 0;
    endtask

    // Hold one raw value for a whole sample period so it is captured by exactly one strobe.
    task automatic sample(input logic b);
        raw_bit = b;
        repeat (SDIV) @(negedge clk);
    endtask

    task automatic pair(input logic a, input logic b);
        sample(a);
        sample(b);
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b0; raw_bit = 1'b0; data_ready = 1'b0;

        // Reset and idle
        do_reset();
        chk("rst_data_out", {24'h0, data_out}, 32'h0);
        chk("rst_valid", {31'h0, data_valid}, 32'h0);
        chk("rst_overflow", {31'h0, overflow}, 32'h0);
        chk("rst_health", {31'h0, health_fail}, 32'h0);
        data_ready = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            raw_bit = 1'($urandom);
            @(negedge clk);
        end
        chk("idle_no_valid", vld_cycles, 32'd0);
        chk("idle_no_bytes", got.size(), 32'd0);

        // Debias: (1,0),(0,1) x4 -> 0xAA
        do_reset();
        data_ready = 1'b1;
        enable = 1'b1;
        repeat (4) begin
            pair(1'b1, 1'b0);
            pair(1'b0, 1'b1);
        end
        repeat (4) @(negedge clk);
        chk("debias_count", got.size(), 32'd1);
        chk("debias_byte", first_byte(), 32'hAA);
        chk("debias_valid_cycles", vld_cycles, 32'd1);
        chk("debias_overflow", {31'h0, overflow}, 32'h0);

        // 00/11 pairs contribute nothing -> 0xFF
        do_reset();
        data_ready = 1'b1;
        enable = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) pair(1'b0, 1'b0);
            else            pair(1'b1, 1'b1);
            pair(1'b1, 1'b0);
        end
        repeat (4) @(negedge clk);
        chk("discard_count", got.size(), 32'd1);
        chk("discard_byte", first_byte(), 32'hFF);
        chk("discard_overflow", {31'h0, overflow}, 32'h0);

        // Backpressure: 0xAA held, following 0xFF dropped with overflow
        do_reset();
        data_ready = 1'b0;
        enable = 1'b1;
        repeat (4) begin
            pair(1'b1, 1'b0);
            pair(1'b0, 1'b1);
        end
        repeat (4) @(negedge clk);
        chk("bp_first_valid", {31'h0, data_valid}, 32'h1);
        chk("bp_first_data", {24'h0, data_out}, 32'hAA);
        chk("bp_first_no_ovf", {31'h0, overflow}, 32'h0);
        repeat (8) pair(1'b1, 1'b0);
        repeat (4) @(negedge clk);
        chk("bp_held_valid", {31'h0, data_valid}, 32'h1);
        chk("bp_held_data", {24'h0, data_out}, 32'hAA);
        chk("bp_overflow", {31'h0, overflow}, 32'h1);
        chk("bp_no_transfer", got.size(), 32'd0);
        data_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("bp_drain_valid", {31'h0, data_valid}, 32'h0);
        chk("bp_drain_count", got.size(), 32'd1);
        chk("bp_drain_byte", first_byte(), 32'hAA);
        chk("bp_ovf_sticky", {31'h0, overflow}, 32'h1);

        // Health: constant 1 trips the repetition test on strobe 32
        do_reset();
        data_ready = 1'b1;
        enable = 1'b1;
        repeat (31) sample(1'b1);
        chk("health_before_32", {31'h0, health_fail}, 32'h0);
        sample(1'b1);
        chk("health_at_32", {31'h0, health_fail}, 32'h1);
        chk("health_no_bytes", got.size(), 32'd0);
        chk("health_no_valid", {31'h0, data_valid}, 32'h0);
        enable = 1'b0;
        repeat (50) @(negedge clk);
        chk("health_sticky", {31'h0, health_fail}, 32'h1);
        do_reset();
        chk("health_cleared", {31'h0, health_fail}, 32'h0);

        // Mid-operation disable discards a partial byte
        do_reset();
        data_ready = 1'b1;
        enable = 1'b1;
        repeat (5) pair(1'b0, 1'b1);
        enable = 1'b0;
        @(negedge clk);
        enable = 1'b1;
        repeat (8) pair(1'b1, 1'b0);
        repeat (4) @(negedge clk);
        chk("disable_count", got.size(), 32'd1);
        chk("disable_byte", first_byte(), 32'hFF);
        chk("disable_overflow", {31'h0, overflow}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
